// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: write-pointer synchronizer, empty/occupancy,
// RAM read addressing and a registered valid/ready output stage.
module async_fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int PW = ADDR_WIDTH + 1;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_sync1;
    logic [PW-1:0]         r_sync2;
    logic [PW-1:0]         r_rptr_bin;
    logic [PW-1:0]         r_rptr_gray;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;

    logic [PW-1:0]         w_wptr_sync_bin;
    logic [PW-1:0]         w_rptr_bin_inc;
    logic [PW-1:0]         w_rptr_gray_inc;
    logic                  w_empty;
    logic                  w_pop;

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign w_wptr_sync_bin[gi] = ^r_sync2[PW-1:gi];
        end
    endgenerate

    assign w_rptr_bin_inc  = r_rptr_bin + PW'(1);
    assign w_rptr_gray_inc = w_rptr_bin_inc ^ (w_rptr_bin_inc >> 1);
    assign w_empty         = (r_rptr_bin == w_wptr_sync_bin);
    assign w_pop           = !w_empty && (!r_out_valid || out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_rptr_bin  <= '0;
            r_rptr_gray <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_sync1 <= wptr_gray;
            r_sync2 <= r_sync1;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_out_data  <= mem_rdata;
                        r_rptr_bin  <= w_rptr_bin_inc;
                        r_rptr_gray <= w_rptr_gray_inc;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Without out_ready everything is frozen; with it we either refill or drain.
                    if (out_ready) begin
                        if (w_pop) begin
                            r_out_data  <= mem_rdata;
                            r_rptr_bin  <= w_rptr_bin_inc;
                            r_rptr_gray <= w_rptr_gray_inc;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_raddr = r_rptr_bin[ADDR_WIDTH-1:0];
    assign rptr_gray = r_rptr_gray;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign empty     = w_empty;
    assign count     = w_wptr_sync_bin - r_rptr_bin;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for async_fifo_rd_ctrl: vector table for the basic/backpressure flow,
// hand-written sequences for reset, full occupancy, pointer wrap and reset during HOLD.
module tb_async_fifo_rd_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  wptr_gray;
    logic [31:0] mem_rdata;
    logic        out_ready;
    logic [2:0]  mem_raddr;
    logic [3:0]  rptr_gray;
    logic [31:0] out_data;
    logic        out_valid;
    logic        empty;
    logic [3:0]  count;

    logic [31:0] mem [8];

    int n_pass;
    int n_total;

    typedef struct {
        logic [3:0]  wptr;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_empty;
        logic [3:0]  exp_count;
        logic [3:0]  exp_rgray;
        logic [2:0]  exp_raddr;
    } vec_t;

    vec_t vecs [11];

    async_fifo_rd_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .wptr_gray (wptr_gray),
        .mem_rdata (mem_rdata),
        .out_ready (out_ready),
        .mem_raddr (mem_raddr),
        .rptr_gray (rptr_gray),
        .out_data  (out_data),
        .out_valid (out_valid),
        .empty     (empty),
        .count     (count)
    );

    // Combinational-read RAM model
    assign mem_rdata = mem[mem_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_rgray"}, 32'(rptr_gray), 32'd0);
        chk({tag, "_data"}, out_data, 32'd0);
        chk({tag, "_raddr"}, 32'(mem_raddr), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] wbin;
        logic [3:0] prev_g;
        logic [2:0] prev_a;
        logic       saw_gwrap;
        logic       saw_awrap;
        int         got;
        int         budget;
        logic [31:0] exp_q [$];

        n_pass = 0;
        n_total = 0;
        for (int i = 0; i < 8; i++) mem[i] = 32'hA5A5_0001 + 32'(i);

        vecs[0]  = '{4'b0001, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 4'd0, 4'b0000, 3'd0};
        vecs[1]  = '{4'b0001, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd1, 4'b0000, 3'd0};
        vecs[2]  = '{4'b0001, 1'b1, 1'b1, 32'hA5A5_0001, 1'b1, 4'd0, 4'b0001, 3'd1};
        vecs[3]  = '{4'b0001, 1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 4'd0, 4'b0001, 3'd1};
        vecs[4]  = '{4'b0110, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 4'd0, 4'b0001, 3'd1};
        vecs[5]  = '{4'b0110, 1'b0, 1'b0, 32'hA5A5_0001, 1'b0, 4'd3, 4'b0001, 3'd1};
        vecs[6]  = '{4'b0110, 1'b0, 1'b1, 32'hA5A5_0002, 1'b0, 4'd2, 4'b0011, 3'd2};
        vecs[7]  = '{4'b0110, 1'b0, 1'b1, 32'hA5A5_0002, 1'b0, 4'd2, 4'b0011, 3'd2};
        vecs[8]  = '{4'b0110, 1'b1, 1'b1, 32'hA5A5_0003, 1'b0, 4'd1, 4'b0010, 3'd3};
        vecs[9]  = '{4'b0110, 1'b1, 1'b1, 32'hA5A5_0004, 1'b1, 4'd0, 4'b0110, 3'd4};
        vecs[10] = '{4'b0110, 1'b1, 1'b0, 32'hA5A5_0004, 1'b1, 4'd0, 4'b0110, 3'd4};

        reset = 1'b1;
        wptr_gray = 4'b0000;
        out_ready = 1'b0;
        step();
        chk_reset_vals("por");
        step();
        reset = 1'b0;

        // Single word, then backpressure with three visible words
        for (int v = 0; v < 11; v++) begin
            wptr_gray = vecs[v].wptr;
            out_ready = vecs[v].ready;
            step();
            $display("vec %0d: wptr=%b rdy=%0d -> valid=%0d data=%h empty=%0d count=%0d rgray=%b raddr=%0d",
                     v, vecs[v].wptr, vecs[v].ready, out_valid, out_data, empty, count, rptr_gray, mem_raddr);
            chk($sformatf("v%0d_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
            chk($sformatf("v%0d_data", v), out_data, vecs[v].exp_data);
            chk($sformatf("v%0d_empty", v), 32'(empty), 32'(vecs[v].exp_empty));
            chk($sformatf("v%0d_count", v), 32'(count), 32'(vecs[v].exp_count));
            chk($sformatf("v%0d_rgray", v), 32'(rptr_gray), 32'(vecs[v].exp_rgray));
            chk($sformatf("v%0d_raddr", v), 32'(mem_raddr), 32'(vecs[v].exp_raddr));
        end

        // Mid-cycle reset takes effect without a clock edge
        wptr_gray = 4'b0000;
        reset = 1'b1;
        #1;
        $display("reset mid-cycle: valid=%0d empty=%0d rgray=%b", out_valid, empty, rptr_gray);
        chk_reset_vals("rst1");
        #1;
        reset = 1'b0;
        step();

        // Full occupancy: 8 words, addresses 0..7 back to back
        wptr_gray = 4'b1100;
        out_ready = 1'b1;
        step();
        chk("full_sync1_empty", 32'(empty), 32'd1);
        step();
        chk("full_count", 32'(count), 32'd8);
        chk("full_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("full_raddr%0d", i), 32'(mem_raddr), 32'(i));
            step();
            $display("full pop %0d: data=%h count=%0d", i, out_data, count);
            chk($sformatf("full_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("full_data%0d", i), out_data, 32'hA5A5_0001 + 32'(i));
        end
        chk("full_end_empty", 32'(empty), 32'd1);
        chk("full_end_count", 32'(count), 32'd0);
        chk("full_end_rgray", 32'(rptr_gray), 32'b1100);
        step();
        chk("full_drain_valid", 32'(out_valid), 32'd0);

        // Wrap: stream 20 words, one write per cycle, read pointer starts at 8
        wbin = 4'd8;
        prev_g = rptr_gray;
        prev_a = mem_raddr;
        saw_gwrap = 1'b0;
        saw_awrap = 1'b0;
        got = 0;
        budget = 0;
        while ((got < 20) && (budget < 60)) begin
            if (budget < 20) begin
                mem[wbin[2:0]] = 32'hC0DE_0000 + 32'(budget);
                exp_q.push_back(32'hC0DE_0000 + 32'(budget));
                wbin = wbin + 4'd1;
                wptr_gray = wbin ^ (wbin >> 1);
            end
            if (out_valid && out_ready) begin
                $display("wrap word %0d: data=%h", got, out_data);
                if (exp_q.size() == 0) begin
                    chk("wrap_dup", out_data, 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("wrap_word%0d", got), out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                got++;
            end
            step();
            if (prev_g == 4'b1000 && rptr_gray == 4'b0000) saw_gwrap = 1'b1;
            if (prev_a == 3'd7 && mem_raddr == 3'd0) saw_awrap = 1'b1;
            prev_g = rptr_gray;
            prev_a = mem_raddr;
            budget++;
        end
        chk("wrap_count", 32'(got), 32'd20);
        chk("wrap_leftover", 32'(exp_q.size()), 32'd0);
        chk("wrap_gray_wrap", 32'(saw_gwrap), 32'd1);
        chk("wrap_addr_wrap", 32'(saw_awrap), 32'd1);
        step();
        chk("wrap_end_empty", 32'(empty), 32'd1);
        chk("wrap_end_valid", 32'(out_valid), 32'd0);
        chk("wrap_end_rgray", 32'(rptr_gray), 32'(wbin ^ (wbin >> 1)));

        // Reset while a word is held under backpressure
        out_ready = 1'b0;
        mem[wbin[2:0]] = 32'h5A5A_1234;
        wbin = wbin + 4'd1;
        wptr_gray = wbin ^ (wbin >> 1);
        repeat (3) step();
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, 32'h5A5A_1234);
        step();
        chk("hold_still_data", out_data, 32'h5A5A_1234);
        chk("hold_still_valid", 32'(out_valid), 32'd1);
        wptr_gray = 4'b0000;
        reset = 1'b1;
        #1;
        $display("reset in HOLD: valid=%0d data=%h rgray=%b", out_valid, out_data, rptr_gray);
        chk_reset_vals("rst2");
        #1;
        reset = 1'b0;
        step();
        mem[0] = 32'hA5A5_0001;
        wptr_gray = 4'b0001;
        out_ready = 1'b1;
        step();
        chk("post_e1_empty", 32'(empty), 32'd1);
        chk("post_e1_valid", 32'(out_valid), 32'd0);
        step();
        chk("post_e2_empty", 32'(empty), 32'd0);
        chk("post_e2_count", 32'(count), 32'd1);
        chk("post_e2_valid", 32'(out_valid), 32'd0);
        step();
        $display("post-reset word: valid=%0d data=%h rgray=%b raddr=%0d", out_valid, out_data, rptr_gray, mem_raddr);
        chk("post_e3_valid", 32'(out_valid), 32'd1);
        chk("post_e3_data", out_data, 32'hA5A5_0001);
        chk("post_e3_rgray", 32'(rptr_gray), 32'b0001);
        chk("post_e3_raddr", 32'(mem_raddr), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
